// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// ad_ip_jesd204_tpl_dac_pkg: shared constants and helpers for the TPL DAC sample adapter
package ad_ip_jesd204_tpl_dac_pkg;
  localparam logic UNF_FILL_ZERO = 1'b0;
  localparam logic UNF_FILL_HOLD = 1'b1;
  localparam logic PAD_LSB = 1'b0;
  localparam logic PAD_MSB = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_elastic_fifo.sv
// ad_ip_jesd204_tpl_dac_elastic_fifo: beat FIFO with wrap-bit pointers and synchronous flush
module ad_ip_jesd204_tpl_dac_elastic_fifo
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int DW = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_XOR = (AW+1)'(FIFO_DEPTH);
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;
  assign full = (wr_ptr ^ rd_ptr) == FULL_XOR;
  assign empty = wr_ptr == rd_ptr;
  assign level = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_sample_adapter.sv
// ad_ip_jesd204_tpl_dac_sample_adapter: buffers DMA beats, converts sample width, masks channels,
// and fills underflow cycles with zeros or the last beat.
module ad_ip_jesd204_tpl_dac_sample_adapter
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_PATH_WIDTH = 2,
  parameter int DMA_BITS_PER_SAMPLE = 16,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int NS = NUM_CHANNELS * DATA_PATH_WIDTH,
  localparam int DW = NS * DMA_BITS_PER_SAMPLE,
  localparam int CW = NS * BITS_PER_SAMPLE,
  localparam int LW = clog2(FIFO_DEPTH) + 1
) (
  input  logic                    link_clk,
  input  logic                    link_resetn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DW-1:0]           s_data,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic [CW-1:0]           m_data,
  input  logic [NUM_CHANNELS-1:0] cfg_enable,
  input  logic                    cfg_pad_msb,
  input  logic                    cfg_unf_hold,
  input  logic                    cfg_flush,
  input  logic                    cfg_unf_clr,
  output logic                    dac_dunf,
  output logic [15:0]             unf_count,
  output logic [LW-1:0]           fifo_level
);
  localparam int D = DMA_BITS_PER_SAMPLE;
  localparam int B = BITS_PER_SAMPLE;
  logic rdy_q, fifo_full, fifo_empty, unf;
  logic [DW-1:0] head;
  logic [CW-1:0] conv;
  // s_ready only depends on registered state, never on m_ready
  assign s_ready = rdy_q && !fifo_full;
  assign unf = m_ready && fifo_empty && !cfg_flush;
  ad_ip_jesd204_tpl_dac_elastic_fifo #(
    .DW(DW),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(link_clk),
    .rst_n(link_resetn),
    .flush(cfg_flush),
    .push(s_valid && s_ready),
    .wr_data(s_data),
    .pop(m_ready),
    .rd_data(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );
  for (genvar i = 0; i < NS; i++) begin : g_smp
    logic [D-1:0] smp;
    logic [B-1:0] c;
    assign smp = head[i*D +: D];
    if (D >= B) begin : g_trunc
      assign c = cfg_pad_msb == PAD_MSB ? smp[B-1:0] : smp[D-1 -: B];
    end else begin : g_ext
      assign c = cfg_pad_msb == PAD_MSB ? {{(B-D){smp[D-1]}}, smp} : {smp, {(B-D){1'b0}}};
    end
    assign conv[i*B +: B] = cfg_enable[i / DATA_PATH_WIDTH] ? c : '0;
  end
  always_ff @(posedge link_clk or negedge link_resetn)
    if (!link_resetn) begin
      rdy_q <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      dac_dunf <= 1'b0;
      unf_count <= '0;
    end else begin
      rdy_q <= 1'b1;
      dac_dunf <= unf;
      if (cfg_flush) begin
        m_valid <= 1'b0;
        m_data <= '0;
      end else if (m_ready) begin
        m_valid <= !fifo_empty;
        m_data <= !fifo_empty ? conv : cfg_unf_hold == UNF_FILL_HOLD ? m_data : '0;
      end
      unf_count <= cfg_unf_clr ? '0 : (unf && unf_count != 16'hFFFF) ? unf_count + 16'd1 : unf_count;
    end
endmodule
